instr_decode_stage: RTL
=======================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter PC_W, default 32, program-counter width.
REQ-002 Parameter CNT_W, default 16, accepted-instruction counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch stage presents an instruction.
REQ-006 in_ready  output  1  stage can accept; driven directly from a flop.
REQ-007 in_instr  input  32  fetched instruction word.
REQ-008 in_pc  input  PC_W  address of in_instr.
REQ-009 flush  input  1  discard all held instructions (branch taken/redirect).
REQ-010 out_valid  output  1  decoded instruction available.
REQ-011 out_ready  input  1  downstream (operand/extension stage) accepts.
REQ-012 out_opcode, out_funct  output  6 each  instr[31:26], instr[5:0].
REQ-013 out_rs, out_rt, out_rd, out_shamt  output  5 each  instr[25:21], [20:16], [15:11], [10:6].
REQ-014 out_imm16  output  16  instr[15:0], raw and unextended; feeds the 16-to-32 sign extender.
REQ-015 out_pc_plus4  output  PC_W  in_pc + 4, modulo 2^PC_W.
REQ-016 out_rtype, out_branch, out_mem, out_illegal  output  1 each  class flags.
REQ-017 out_count  output  CNT_W  number of instructions accepted on the input.

Function
REQ-018 Accept on the input SHALL occur when in_valid && in_ready at a rising edge; transfer on the output SHALL occur when out_valid && out_ready.
REQ-019 The stage SHALL be a 2-entry skid buffer (main + skid register) with FSM states EMPTY, ONE, TWO.
REQ-020 EMPTY: accept -> ONE. ONE: accept without transfer -> TWO; transfer without accept -> EMPTY; both or neither -> ONE. TWO: transfer -> ONE; the skid entry moves to main in the same edge.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; out_valid SHALL be 1 in ONE and TWO.
REQ-022 Latency SHALL be one cycle: an instruction accepted at edge N is presented at out_* after edge N when the buffer was EMPTY.
REQ-023 Fields, class flags and pc_plus4 SHALL be computed at accept and stored registered; out_* SHALL be stable while out_valid && !out_ready.
REQ-024 Order SHALL be preserved; no instruction is ever duplicated or dropped except by flush.
REQ-025 Class decode: opcode 0x00 -> out_rtype; 0x04, 0x05 -> out_branch; 0x23, 0x2B -> out_mem; 0x02, 0x08, 0x0C, 0x0D -> no flag; every other opcode -> out_illegal. At most one flag SHALL be set.
REQ-026 flush SHALL take priority over every other event: next state EMPTY, in_ready=1, out_valid=0; an instruction offered in the flush cycle SHALL NOT be accepted or counted.
REQ-027 out_count SHALL increment by 1 per accept, wrap from 2^CNT_W-1 to 0, and SHALL NOT be affected by flush.
REQ-028 When out_valid=0, out_* data values are don't-care but SHALL hold their last value (no X after reset).

Reset
REQ-029 On rst_n=0 the state SHALL go to EMPTY immediately: in_ready=1, out_valid=0, out_count=0, all data/flag registers 0.
REQ-030 Reset asserted mid-transfer SHALL discard both entries; the first accept after release SHALL occur on the first edge with rst_n=1 and in_valid=1.

Structure
REQ-031 Opcode constants (R-type, BEQ, BNE, LW, SW, J, ADDI, ANDI, ORI) and the state encoding SHALL live in a shared package used by the decoder and the control unit.
REQ-032 Field/class decode SHALL be one combinational sub-module, instr_field_decode, instantiated once on the input path.

Verification
REQ-033 Reset, then in_instr=0x2009FFFC (addi), in_pc=0x100, out_ready=1 -> next cycle out_valid=1, out_rs=0, out_rt=9, out_imm16=0xFFFC, out_pc_plus4=0x104, all flags 0, out_count=1.
REQ-034 out_ready=0, three back-to-back offers -> two accepted, in_ready=0 after the second edge; raise out_ready -> outputs in the original order, third accepted once in_ready returns.
REQ-035 Buffer in TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_count unchanged.
REQ-036 Opcodes 0x00, 0x04, 0x23, 0x3F -> out_rtype, out_branch, out_mem, out_illegal respectively, one flag each.
REQ-037 CNT_W=4, 17 accepts -> out_count=1; in_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000.
REQ-038 rst_n pulsed low asynchronously between edges while in ONE -> out_valid=0 before the next edge, out_count=0.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared opcode constants, FSM state encoding and decoded-field layout
// for the instruction decode stage and its field decoder.
package instr_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_MEM     = 3'd3,
    CLS_ILLEGAL = 3'd4
  } class_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        rtype;
    logic        branch;
    logic        mem;
    logic        illegal;
  } fields_t;

  // Mapping to a single class makes the flags one-hot (or all zero) by construction.
  function automatic class_e classify(input logic [5:0] op);
    class_e c;
    case (op)
      OP_RTYPE:                       c = CLS_RTYPE;
      OP_BEQ, OP_BNE:                 c = CLS_BRANCH;
      OP_LW, OP_SW:                   c = CLS_MEM;
      OP_J, OP_ADDI, OP_ANDI, OP_ORI: c = CLS_NONE;
      default:                        c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and downstream-side handshake bundle of the decode stage.
// slave = the decode stage, master = its environment.
interface instr_decode_stage_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_opcode;
  logic [5:0]       out_funct;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [4:0]       out_shamt;
  logic [15:0]      out_imm16;
  logic [PC_W-1:0]  out_pc_plus4;
  logic             out_rtype;
  logic             out_branch;
  logic             out_mem;
  logic             out_illegal;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt, out_rd,
           out_shamt, out_imm16, out_pc_plus4, out_rtype, out_branch, out_mem,
           out_illegal, out_count
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt, out_rd,
           out_shamt, out_imm16, out_pc_plus4, out_rtype, out_branch, out_mem,
           out_illegal, out_count
  );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational field extraction, class decode and pc+4 for one
// instruction on the input path of the decode stage.
module instr_field_decode
  import instr_decode_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output fields_t         fields_o,
  output logic [PC_W-1:0] pc_plus4_o
);

  class_e cls;

  always_comb begin
    cls              = classify(instr_i[31:26]);
    fields_o         = '0;
    fields_o.opcode  = instr_i[31:26];
    fields_o.rs      = instr_i[25:21];
    fields_o.rt      = instr_i[20:16];
    fields_o.rd      = instr_i[15:11];
    fields_o.shamt   = instr_i[10:6];
    fields_o.funct   = instr_i[5:0];
    fields_o.imm16   = instr_i[15:0];
    fields_o.rtype   = (cls == CLS_RTYPE);
    fields_o.branch  = (cls == CLS_BRANCH);
    fields_o.mem     = (cls == CLS_MEM);
    fields_o.illegal = (cls == CLS_ILLEGAL);
  end

  assign pc_plus4_o = pc_i + PC_W'(4);

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: two-entry skid buffer holding pre-decoded instructions,
// with flush, registered handshakes and an accepted-instruction counter.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | nothing held, in_ready=1, out_valid=0
// ST_ONE   | main entry valid, in_ready=1, out_valid=1
// ST_TWO   | main+skid valid, in_ready=0, out_valid=1
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_decode_stage_if.slave  stg_if
);

  fields_t          dec_fields;
  logic [PC_W-1:0]  dec_pc4;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  fields_t          main_q;
  fields_t          skid_q;
  logic [PC_W-1:0]  main_pc4_q;
  logic [PC_W-1:0]  skid_pc4_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic accept;
  logic xfer;

  instr_field_decode #(.PC_W(PC_W)) u_field_decode (
    .instr_i    (stg_if.in_instr),
    .pc_i       (stg_if.in_pc),
    .fields_o   (dec_fields),
    .pc_plus4_o (dec_pc4)
  );

  // Flush masks both handshakes so nothing is accepted or retired that cycle.
  assign accept  = stg_if.in_valid && in_ready_q && !stg_if.flush;
  assign xfer    = out_valid_q && stg_if.out_ready && !stg_if.flush;
  assign count_d = count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      main_pc4_q  <= '0;
      skid_pc4_q  <= '0;
    end else if (stg_if.flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= dec_fields;
            main_pc4_q  <= dec_pc4;
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !xfer) begin
            skid_q      <= dec_fields;
            skid_pc4_q  <= dec_pc4;
            state_q     <= ST_TWO;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (accept && xfer) begin
            main_q      <= dec_fields;
            main_pc4_q  <= dec_pc4;
          end else if (xfer) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            main_q      <= skid_q;
            main_pc4_q  <= skid_pc4_q;
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_d;
    end
  end

  assign stg_if.in_ready     = in_ready_q;
  assign stg_if.out_valid    = out_valid_q;
  assign stg_if.out_opcode   = main_q.opcode;
  assign stg_if.out_funct    = main_q.funct;
  assign stg_if.out_rs       = main_q.rs;
  assign stg_if.out_rt       = main_q.rt;
  assign stg_if.out_rd       = main_q.rd;
  assign stg_if.out_shamt    = main_q.shamt;
  assign stg_if.out_imm16    = main_q.imm16;
  assign stg_if.out_pc_plus4 = main_pc4_q;
  assign stg_if.out_rtype    = main_q.rtype;
  assign stg_if.out_branch   = main_q.branch;
  assign stg_if.out_mem      = main_q.mem;
  assign stg_if.out_illegal  = main_q.illegal;
  assign stg_if.out_count    = count_q;

endmodule
